// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: FSM state encoding and the
// data/select widths used by the initiator and its bench.
package wb_pkg;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/wb_timeout_counter.sv
// ACK wait counter for the Wishbone initiator.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (start of a bus cycle)
//   enable   : count one more cycle without ACK
//   limit    : timeout in cycles; 0 disables expiry
//   expired  : count has reached limit-1 (this edge would be the limit-th)
module wb_timeout_counter import wb_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + ONE;
  end

  assign expired = (limit != '0) && (count == limit - ONE);
endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator. A valid/ready command is
// turned into one registered bus cycle; the slave's ACK (or an ACK timeout)
// produces one valid/ready response.
//   CLK_I, RST_I       : clock, async active-high reset
//   req_*              : command (addr, wdata, we, sel) with valid/ready
//   rsp_*              : response (rdata, err=timeout) with valid/ready
//   ADR_O..CYC_O, DAT_I, ACK_I : Wishbone classic initiator side
module wb_initiator import wb_pkg::*; #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter int          ADDR_W         = 32
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DAT_W-1:0]  req_wdata,
  input  logic              req_we,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DAT_W-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DAT_W-1:0]  DAT_O,
  input  logic [DAT_W-1:0]  DAT_I,
  output logic              WE_O,
  output logic [SEL_W-1:0]  SEL_O,
  output logic              STB_O,
  output logic              CYC_O,
  input  logic              ACK_I
);
  state_t state, state_nxt;
  logic   accept, ack_hit, to_hit, rsp_done, expired;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  // ACK is only meaningful in BUS and beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_nxt = BUS;
      end
      BUS: begin
        ack_hit = ACK_I;
        to_hit  = !ACK_I && expired;
        if (ack_hit || to_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_done = rsp_ready;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  wb_timeout_counter u_cnt (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clear   (accept),
    .enable  ((state == BUS) && !ACK_I),
    .limit   (TIMEOUT_CYCLES),
    .expired (expired)
  );

  // All bus and response outputs are registers; address/data/sel only load
  // on acceptance so they stay put for the whole cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ADR_O     <= '0;
      DAT_O     <= '0;
      WE_O      <= 1'b0;
      SEL_O     <= '0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        ADR_O <= req_addr;
        DAT_O <= req_wdata;
        WE_O  <= req_we;
        SEL_O <= req_sel;
        CYC_O <= 1'b1;
        STB_O <= 1'b1;
      end
      if (ack_hit || to_hit) begin
        CYC_O     <= 1'b0;
        STB_O     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= to_hit;
        rsp_rdata <= (ack_hit && !WE_O) ? DAT_I : '0;
      end
      if (rsp_done) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator (TIMEOUT_CYCLES = 8): directed scenarios then
// randomized transactions checked against a per-transaction outcome model.
module tb_wb_initiator;
  import wb_pkg::*;

  localparam int T = 8;

  logic        CLK_I = 1'b0, RST_I = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ADR_O, DAT_O, DAT_I = '0;
  logic        WE_O, STB_O, CYC_O, ACK_I = 1'b0;
  logic [3:0]  SEL_O;

  int tests = 0, fails = 0;

  wb_initiator #(.TIMEOUT_CYCLES(16'd8), .ADDR_W(32)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O), .SEL_O(SEL_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction. The slave raises ACK after wait_n STB cycles without
  // it (ACK seen on BUS edge wait_n+1); the response is left unconsumed for
  // hold cycles. Outcome: timeout if wait_n >= T (bus held exactly T edges),
  // otherwise wait_n+1 edges and read data (0 for writes).
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic we, input logic [3:0] sel, input logic [31:0] sdata,
                     input int wait_n, input int hold);
    bit          exp_err  = (wait_n >= T);
    int          exp_edge = exp_err ? T : wait_n + 1;
    logic [31:0] exp_rd   = (exp_err || we) ? 32'h0 : sdata;
    int          n = 0;
    bit          done = 0;
    logic [31:0] rd0;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we; req_sel = sel;
    @(negedge CLK_I);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    chk("cyc_start", CYC_O, 1'b1);
    chk("stb_start", STB_O, 1'b1);
    chk("we_o", WE_O, we);
    while (!done && n < 40) begin
      ACK_I = (n == wait_n);
      DAT_I = ACK_I ? sdata : $urandom;
      @(negedge CLK_I);
      n++;
      if (CYC_O) begin
        chk("adr_stable", ADR_O, addr);
        chk("dat_stable", DAT_O, wdata);
        chk("sel_stable", SEL_O, sel);
        chk("req_ready_bus", req_ready, 1'b0);
      end else done = 1;
    end
    ACK_I = 1'b0;
    chk("bus_edges", n, exp_edge);
    chk("stb_end", STB_O, 1'b0);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    rd0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      ACK_I = $urandom_range(0, 1);
      @(negedge CLK_I);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, rd0);
      chk("hold_ready", req_ready, 1'b0);
    end
    ACK_I = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK_I);
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_cyc", CYC_O, 1'b0);
    chk("rst_stb", STB_O, 1'b0);
    chk("rst_adr", ADR_O, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge CLK_I); @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst_req_ready", req_ready, 1'b1);

    // zero-wait read
    txn(32'h1250_0004, 32'h0, 1'b0, 4'hF, 32'h0000_0060, 0, 0);
    // write with 3 wait cycles
    txn(32'h1250_0000, 32'h41, 1'b1, 4'b0001, 32'hDEAD_BEEF, 3, 0);
    // no ACK -> timeout after 8 edges
    txn(32'h1250_0008, 32'h0, 1'b0, 4'hF, 32'h1234_5678, 30, 0);
    // ACK on the 8th edge wins over timeout
    txn(32'h1250_000C, 32'h0, 1'b0, 4'hF, 32'hCAFE_0001, 7, 0);
    // response back-pressure for 5 cycles, then immediate next command
    txn(32'h1250_0010, 32'h0, 1'b0, 4'hF, 32'h0000_0099, 2, 5);
    txn(32'h1250_0014, 32'h77, 1'b1, 4'b1100, 32'h0, 1, 0);

    // reset during BUS: outputs drop with no clock edge, late ACK ignored
    req_valid = 1'b1; req_addr = 32'hAAAA_0000; req_we = 1'b0; req_sel = 4'hF;
    @(negedge CLK_I);
    req_valid = 1'b0;
    chk("mid_cyc_before", CYC_O, 1'b1);
    #2 RST_I = 1'b1;
    #1;
    chk("mid_rst_cyc", CYC_O, 1'b0);
    chk("mid_rst_stb", STB_O, 1'b0);
    chk("mid_rst_adr", ADR_O, 32'h0);
    chk("mid_rst_rsp", rsp_valid, 1'b0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    ACK_I = 1'b1; DAT_I = 32'h5555_5555;
    @(negedge CLK_I); @(negedge CLK_I);
    chk("late_ack_rsp", rsp_valid, 1'b0);
    chk("late_ack_cyc", CYC_O, 1'b0);
    chk("late_ack_ready", req_ready, 1'b1);
    ACK_I = 1'b0;

    for (int k = 0; k < 25; k++)
      txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
          $urandom, $urandom_range(0, 11), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
